stream_merge: RTL and testbench

Parametrised N-to-1 merger for the 32-bit stb/ack streams used between the generated processes in the top-level user design. It merges several producer streams onto one consumer port (e.g. many processes sharing the single rs232_tx or eth_tx output) using round-robin arbitration. An optional packet mode holds the grant until a terminator word. A lock timeout releases a stalled channel and raises a sticky exception for the top-level exception OR.

---
 rtl/stream_pkg.sv | 16 +
 rtl/rr_pick.sv | 25 ++
 rtl/stream_merge.sv | 139 +++++++++++++
 tb/tb_stream_merge.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types and helpers for the stb/ack stream blocks (merge, and the later demux).
package stream_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: first requester after i_last, wrapping modulo N.
module rr_pick
    import stream_pkg::*;
#(
    parameter  int N  = 2,
    localparam int CW = chan_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [CW-1:0] i_last,
    output logic [CW-1:0] o_sel,
    output logic          o_any
);

    always_comb begin
        o_sel = '0;
        o_any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!o_any && i_req[(int'(i_last) + k) % N]) begin
                o_sel = CW'((int'(i_last) + k) % N);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_merge.sv
// N-to-1 stb/ack stream merger with round-robin arbitration, optional packet lock
// held until a terminator word, and a lock timeout that raises a sticky exception.
//
// state | meaning
// IDLE  | round-robin pick among requesting channels, word-level grant
// LOCK  | grant held on r_lock_chan until TERM is transferred or the timeout fires
module stream_merge
    import stream_pkg::*;
#(
    parameter  int               N       = 2,
    parameter  int               WIDTH   = DATA_W_DEF,
    parameter  int               PACKET  = 0,
    parameter  logic [WIDTH-1:0] TERM    = '0,
    parameter  int               TIMEOUT = 1024,
    localparam int               CW      = chan_w(N),
    localparam int               TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N*WIDTH-1:0]   i_in_data,
    input  logic [N-1:0]         i_in_stb,
    output logic [N-1:0]         o_in_ack,
    output logic [WIDTH-1:0]     o_out_data,
    output logic                 o_out_stb,
    input  logic                 i_out_ack,
    output logic [CW-1:0]        o_out_chan,
    output logic                 o_exception
);

    state_t           r_state;
    logic [CW-1:0]    r_last;
    logic [CW-1:0]    r_lock_chan;
    logic [CW-1:0]    r_out_chan;
    logic [TW-1:0]    r_idle_cnt;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_stb;
    logic             r_exc;

    logic [CW-1:0]    w_pick_sel;
    logic             w_pick_any;
    logic [CW-1:0]    w_sel;
    logic [N-1:0]     w_sel_oh;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_ready;
    logic             w_sel_stb;
    logic             w_xfer;
    logic             w_is_term;
    logic             w_timeout;

    rr_pick #(.N(N)) u_pick (
        .i_req  (i_in_stb),
        .i_last (r_last),
        .o_sel  (w_pick_sel),
        .o_any  (w_pick_any)
    );

    assign w_sel = (r_state == LOCK) ? r_lock_chan : w_pick_sel;

    always_comb begin
        w_sel_oh   = '0;
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_sel == CW'(i)) begin
                w_sel_oh[i] = 1'b1;
                w_sel_data  = i_in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ready   = !r_out_stb || i_out_ack;
    assign w_sel_stb = (r_state == LOCK) ? |(i_in_stb & w_sel_oh) : w_pick_any;
    assign w_xfer    = w_ready && w_sel_stb;
    assign w_is_term = (w_sel_data == TERM);
    assign w_timeout = (TIMEOUT != 0) && (r_idle_cnt == TW'(TIMEOUT - 1));

    // Combinational from i_out_ack so a full register can drain and refill in one cycle.
    assign o_in_ack = (i_rst_n && w_xfer) ? w_sel_oh : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_last      <= CW'(N - 1);
            r_lock_chan <= '0;
            r_out_chan  <= '0;
            r_idle_cnt  <= '0;
            r_out_data  <= '0;
            r_out_stb   <= 1'b0;
            r_exc       <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_out_data <= w_sel_data;
                r_out_chan <= w_sel;
                r_out_stb  <= 1'b1;
            end else if (i_out_ack) begin
                r_out_stb  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        if (PACKET != 0 && !w_is_term) begin
                            r_lock_chan <= w_sel;
                            r_idle_cnt  <= '0;
                            r_state     <= LOCK;
                        end else begin
                            r_last <= w_sel;
                        end
                    end
                end
                LOCK: begin
                    if (w_xfer) begin
                        if (w_is_term) begin
                            r_last  <= r_lock_chan;
                            r_state <= IDLE;
                        end else begin
                            r_idle_cnt <= '0;
                        end
                    end else if (!w_sel_stb) begin
                        // Only a silent producer ages the lock; backpressure does not.
                        if (w_timeout) begin
                            r_last  <= r_lock_chan;
                            r_exc   <= 1'b1;
                            r_state <= IDLE;
                        end else if (r_idle_cnt != '1) begin
                            r_idle_cnt <= r_idle_cnt + TW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_stb   = r_out_stb;
    assign o_out_chan  = r_out_chan;
    assign o_exception = r_exc;

endmodule

// File: tb/tb_stream_merge.sv
// Directed bench for stream_merge: word-level round robin (N=4), packet mode with
// timeout (N=2), and single-channel pass-through (N=1).
module tb_stream_merge;

    logic clk;
    logic rst_n;

    logic [127:0] a_data;
    logic [3:0]   a_stb, a_iack;
    logic [31:0]  a_odata;
    logic         a_ostb, a_oack, a_exc;
    logic [1:0]   a_ochan;

    logic [63:0]  b_data;
    logic [1:0]   b_stb, b_iack;
    logic [31:0]  b_odata;
    logic         b_ostb, b_oack, b_exc;
    logic [0:0]   b_ochan;

    logic [31:0]  c_data;
    logic [0:0]   c_stb, c_iack;
    logic [31:0]  c_odata;
    logic         c_ostb, c_oack, c_exc;
    logic [0:0]   c_ochan;

    int total = 0;
    int bad   = 0;

    logic [31:0] seq0 [3];
    logic [31:0] seq1 [2];
    logic [31:0] exp_d [5];
    logic [0:0]  exp_c [5];
    logic [31:0] got_d [8];
    logic [0:0]  got_c [8];

    stream_merge #(.N(4), .WIDTH(32), .PACKET(0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_data(a_data), .i_in_stb(a_stb),
        .o_in_ack(a_iack), .o_out_data(a_odata), .o_out_stb(a_ostb),
        .i_out_ack(a_oack), .o_out_chan(a_ochan), .o_exception(a_exc)
    );

    stream_merge #(.N(2), .WIDTH(32), .PACKET(1), .TERM(32'h0), .TIMEOUT(8)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_data(b_data), .i_in_stb(b_stb),
        .o_in_ack(b_iack), .o_out_data(b_odata), .o_out_stb(b_ostb),
        .i_out_ack(b_oack), .o_out_chan(b_ochan), .o_exception(b_exc)
    );

    stream_merge #(.N(1), .WIDTH(32)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_data(c_data), .i_in_stb(c_stb),
        .o_in_ack(c_iack), .o_out_data(c_odata), .o_out_stb(c_ostb),
        .i_out_ack(c_oack), .o_out_chan(c_ochan), .o_exception(c_exc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0, p1, n_out;
        logic [1:0] ackd;

        seq0  = '{32'h41, 32'h42, 32'h00};
        seq1  = '{32'h61, 32'h00};
        exp_d = '{32'h41, 32'h42, 32'h00, 32'h61, 32'h00};
        exp_c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n  = 1'b1;
        a_data = {32'h13, 32'h12, 32'h11, 32'h10};
        a_stb  = 4'hF;
        a_oack = 1'b1;
        b_data = '0;
        b_stb  = '0;
        b_oack = 1'b1;
        c_data = '0;
        c_stb  = '0;
        c_oack = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ostb",  {63'h0, a_ostb}, 64'h0);
        chk("rst_odata", {32'h0, a_odata}, 64'h0);
        chk("rst_ochan", {62'h0, a_ochan}, 64'h0);
        chk("rst_exc",   {63'h0, a_exc}, 64'h0);
        chk("rst_iack",  {60'h0, a_iack}, 64'h0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("a_first_ack", {60'h0, a_iack}, 64'h1);

        // Word-level round robin, one word per cycle.
        for (int k = 0; k < 5; k++) begin
            step();
            chk("a_rr_chan", {62'h0, a_ochan}, 64'(k % 4));
            chk("a_rr_data", {32'h0, a_odata}, 64'(32'h10 + k % 4));
            chk("a_rr_stb",  {63'h0, a_ostb}, 64'h1);
        end

        // Backpressure: word 0x10 from ch0 held for 5 cycles.
        a_oack = 1'b0;
        #1;
        chk("a_bp_ack0", {60'h0, a_iack}, 64'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("a_bp_data", {32'h0, a_odata}, 64'h10);
            chk("a_bp_stb",  {63'h0, a_ostb}, 64'h1);
            chk("a_bp_iack", {60'h0, a_iack}, 64'h0);
        end
        a_oack = 1'b1;
        #1;
        chk("a_rel_iack", {60'h0, a_iack}, 64'h2);
        step();
        chk("a_rel_data", {32'h0, a_odata}, 64'h11);
        chk("a_rel_chan", {62'h0, a_ochan}, 64'h1);
        a_stb = 4'h0;
        step();
        chk("a_drain_stb", {63'h0, a_ostb}, 64'h0);

        // Packet mode: two packets started together, no interleaving.
        p0 = 0;
        p1 = 0;
        n_out = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            b_stb[0] = (p0 < 3);
            b_stb[1] = (p1 < 2);
            if (p0 < 3) b_data[31:0]  = seq0[p0];
            if (p1 < 2) b_data[63:32] = seq1[p1];
            #1;
            ackd = b_iack;
            chk("b_ack_onehot", {63'h0, (ackd != 2'b11)}, 64'h1);
            step();
            if (ackd[0]) p0++;
            if (ackd[1]) p1++;
            if (b_ostb && n_out < 8) begin
                got_d[n_out] = b_odata;
                got_c[n_out] = b_ochan;
                n_out++;
            end
        end
        chk("b_pkt_count", 64'(n_out), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < n_out) begin
                chk("b_pkt_data", {32'h0, got_d[i]}, {32'h0, exp_d[i]});
                chk("b_pkt_chan", {63'h0, got_c[i]}, {63'h0, exp_c[i]});
            end
        end

        // Timeout: ch0 locks with 0x41 then goes silent while ch1 waits.
        b_stb  = 2'b11;
        b_data = {32'h61, 32'h41};
        #1;
        chk("b_to_first_ack", {62'h0, b_iack}, 64'h1);
        step();
        chk("b_to_first_data", {32'h0, b_odata}, 64'h41);
        b_stb = 2'b10;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("b_to_exc_low", {63'h0, b_exc}, 64'h0);
            chk("b_to_iack_low", {62'h0, b_iack}, 64'h0);
        end
        step();
        chk("b_to_exc_set", {63'h0, b_exc}, 64'h1);
        chk("b_to_ch1_ack", {62'h0, b_iack}, 64'h2);
        step();
        chk("b_to_ch1_data", {32'h0, b_odata}, 64'h61);
        chk("b_to_ch1_chan", {63'h0, b_ochan}, 64'h1);
        chk("b_to_exc_sticky", {63'h0, b_exc}, 64'h1);

        // Asynchronous reset mid-packet (ch1 locked, word in output register).
        b_stb = 2'b11;
        #3 rst_n = 1'b0;
        #1;
        chk("b_rst_ostb", {63'h0, b_ostb}, 64'h0);
        chk("b_rst_exc",  {63'h0, b_exc}, 64'h0);
        chk("b_rst_iack", {62'h0, b_iack}, 64'h0);
        step();
        step();
        rst_n  = 1'b1;
        b_data = {32'h66, 32'h55};
        #1;
        chk("b_post_rst_ack", {62'h0, b_iack}, 64'h1);
        step();
        chk("b_post_rst_chan", {63'h0, b_ochan}, 64'h0);
        chk("b_post_rst_data", {32'h0, b_odata}, 64'h55);
        b_stb = 2'b00;

        // Single channel pass-through.
        c_stb  = 1'b1;
        c_data = 32'hA5;
        #1;
        chk("c_iack", {63'h0, c_iack}, 64'h1);
        step();
        chk("c_data0", {32'h0, c_odata}, 64'hA5);
        chk("c_chan0", {63'h0, c_ochan}, 64'h0);
        chk("c_stb0",  {63'h0, c_ostb}, 64'h1);
        c_data = 32'h5A;
        step();
        chk("c_data1", {32'h0, c_odata}, 64'h5A);
        chk("c_chan1", {63'h0, c_ochan}, 64'h0);
        c_stb = 1'b0;
        step();
        chk("c_stb_off", {63'h0, c_ostb}, 64'h0);
        chk("c_exc", {63'h0, c_exc}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
